// File: rtl/t_junction_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : t_junction_phase_scheduler
// Description : Phase sequencer / arbiter for a three-approach T-junction with
//               round-robin service, pedestrian walk phases and emergency
//               preemption. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module t_junction_phase_scheduler #(
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 8,
    parameter int EMG_HOLD  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] veh_req,
    input  logic [1:0] ped_req,
    input  logic [2:0] emg_req,
    output logic [8:0] lights,
    output logic [1:0] walk,
    output logic       buzzer,
    output logic       emg_active,
    output logic [1:0] phase
);

    localparam logic [7:0] c_green_min_m1 = 8'(GREEN_MIN - 1);
    localparam logic [7:0] c_green_max_m1 = 8'(GREEN_MAX - 1);
    localparam logic [7:0] c_yellow_m1    = 8'(YELLOW_T - 1);
    localparam logic [7:0] c_allred_m1    = 8'(ALLRED_T - 1);
    localparam logic [7:0] c_walk_m1      = 8'(WALK_T - 1);
    localparam logic [7:0] c_emg_hold_m1  = 8'(EMG_HOLD - 1);
    localparam logic [7:0] c_cnt_sat      = 8'hFF;

    localparam logic [2:0] c_lamp_red     = 3'b100;
    localparam logic [2:0] c_lamp_yellow  = 3'b010;
    localparam logic [2:0] c_lamp_green   = 3'b001;

    typedef enum logic [2:0] {
        S_ALLRED = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_WALK   = 3'd3,
        S_EMG    = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_phase;
    logic [1:0] w_phase_nxt;
    logic [7:0] r_cnt;
    logic [1:0] r_ped_pending;
    logic [1:0] r_walk;
    logic [8:0] r_lights;
    logic       r_buzzer;
    logic       r_emg_active;

    logic       w_emg_any;
    logic [1:0] w_emg_win;
    logic       w_own_veh;
    logic       w_own_emg;
    logic       w_other_demand;
    logic [1:0] w_sel_phase;
    logic [1:0] w_ped_next;
    logic       w_walk_entry;

    // One-hot approach mask; the unused code 3 selects nothing.
    function automatic logic [2:0] f_mask(input logic [1:0] p);
        logic [2:0] m;
        case (p)
            2'd0:    m = 3'b001;
            2'd1:    m = 3'b010;
            2'd2:    m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // Fixed-priority emergency winner, lowest index first.
    function automatic logic [1:0] f_winner(input logic [2:0] e);
        logic [1:0] w;
        if (e[0])
            w = 2'd0;
        else if (e[1])
            w = 2'd1;
        else
            w = 2'd2;
        return w;
    endfunction

    // Round-robin search phase+1, phase+2, phase; idle junction just advances.
    function automatic logic [1:0] f_select(input logic [1:0] p, input logic [2:0] v);
        logic [1:0] n1;
        logic [1:0] n2;
        logic [1:0] n0;
        logic [1:0] s;
        case (p)
            2'd0: begin
                n1 = 2'd1; n2 = 2'd2; n0 = 2'd0;
            end
            2'd1: begin
                n1 = 2'd2; n2 = 2'd0; n0 = 2'd1;
            end
            default: begin
                n1 = 2'd0; n2 = 2'd1; n0 = 2'd2;
            end
        endcase
        if (|(v & f_mask(n1)))
            s = n1;
        else if (|(v & f_mask(n2)))
            s = n2;
        else if (|(v & f_mask(n0)))
            s = n0;
        else
            s = n1;
        return s;
    endfunction

    function automatic logic [8:0] f_lamps(input state_t s, input logic [1:0] p);
        logic [8:0] l;
        logic [2:0] code;
        l    = {c_lamp_red, c_lamp_red, c_lamp_red};
        code = c_lamp_red;
        case (s)
            S_GREEN, S_EMG: code = c_lamp_green;
            S_YELLOW:       code = c_lamp_yellow;
            default:        code = c_lamp_red;
        endcase
        case (p)
            2'd0:    l[2:0] = code;
            2'd1:    l[5:3] = code;
            2'd2:    l[8:6] = code;
            default: l      = {c_lamp_red, c_lamp_red, c_lamp_red};
        endcase
        return l;
    endfunction

    assign w_emg_any      = |emg_req;
    assign w_emg_win      = f_winner(emg_req);
    assign w_own_veh      = |(veh_req & f_mask(r_phase));
    assign w_own_emg      = |(emg_req & f_mask(r_phase));
    assign w_other_demand = (|(veh_req & ~f_mask(r_phase))) || (|r_ped_pending);
    assign w_sel_phase    = f_select(r_phase, veh_req);
    assign w_ped_next     = r_ped_pending | ped_req;
    assign w_walk_entry   = (r_state != S_WALK) && (w_state_nxt == S_WALK);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        case (r_state)
            S_GREEN: begin
                // Preemption is immediate; a green already on the winner skips yellow.
                if (w_emg_any) begin
                    if (w_emg_win == r_phase)
                        w_state_nxt = S_EMG;
                    else
                        w_state_nxt = S_YELLOW;
                end else if (tick && (r_cnt >= c_green_min_m1) && w_other_demand &&
                             (!w_own_veh || (r_cnt >= c_green_max_m1))) begin
                    w_state_nxt = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (tick && (r_cnt == c_yellow_m1))
                    w_state_nxt = S_ALLRED;
            end
            S_ALLRED: begin
                if (tick && (r_cnt == c_allred_m1)) begin
                    if (w_emg_any) begin
                        w_state_nxt = S_EMG;
                        w_phase_nxt = w_emg_win;
                    end else if (|r_ped_pending) begin
                        w_state_nxt = S_WALK;
                    end else begin
                        w_state_nxt = S_GREEN;
                        w_phase_nxt = w_sel_phase;
                    end
                end
            end
            S_WALK: begin
                if (w_emg_any) begin
                    w_state_nxt = S_ALLRED;
                end else if (tick && (r_cnt == c_walk_m1)) begin
                    w_state_nxt = S_GREEN;
                    w_phase_nxt = w_sel_phase;
                end
            end
            S_EMG: begin
                // r_phase holds the grant for the whole emergency.
                if (tick && !w_own_emg && (r_cnt >= c_emg_hold_m1))
                    w_state_nxt = S_YELLOW;
            end
            default: begin
                w_state_nxt = S_ALLRED;
                w_phase_nxt = 2'd2;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_ALLRED;
            r_phase       <= 2'd2;
            r_cnt         <= 8'd0;
            r_ped_pending <= 2'b00;
            r_walk        <= 2'b00;
            r_lights      <= {c_lamp_red, c_lamp_red, c_lamp_red};
            r_buzzer      <= 1'b0;
            r_emg_active  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;

            if (w_state_nxt != r_state)
                r_cnt <= 8'd0;
            else if (tick && (r_cnt != c_cnt_sat))
                r_cnt <= r_cnt + 8'd1;

            // Walk shows what was pending on entry; later presses queue up.
            if (w_walk_entry) begin
                r_ped_pending <= 2'b00;
                r_walk        <= w_ped_next;
            end else begin
                r_ped_pending <= w_ped_next;
                if (w_state_nxt != S_WALK)
                    r_walk <= 2'b00;
            end

            r_lights     <= f_lamps(w_state_nxt, w_phase_nxt);
            r_buzzer     <= (w_state_nxt == S_EMG);
            r_emg_active <= (w_state_nxt == S_EMG);
        end
    end

    assign lights     = r_lights;
    assign walk       = r_walk;
    assign buzzer     = r_buzzer;
    assign emg_active = r_emg_active;
    assign phase      = r_phase;

endmodule
`default_nettype wire

// File: doc/t_junction_phase_scheduler.md
Name: t_junction_phase_scheduler

Overview:
- Phase sequencer and arbiter for a three-approach T-junction. Approach 0 is main-left, 1 is main-right, 2 is side road.
- Decides which approach owns the junction. Serves approaches round-robin and interleaves pedestrian walk phases.
- Arbitrates emergency preemption requests from all three approaches.
- Drives the lamp, walk and buzzer outputs consumed by the signal-head drivers. Sits directly above the per-road signal logic.

Parameters:
- GREEN_MIN, 10: minimum green time in ticks.
- GREEN_MAX, 30: maximum green time when the served approach keeps demanding.
- YELLOW_T, 3: yellow duration in ticks.
- ALLRED_T, 2: all-red clearance in ticks.
- WALK_T, 8: pedestrian walk duration in ticks.
- EMG_HOLD, 20: minimum emergency green in ticks.
- All parameters are 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle 1 s timing enable
- veh_req  in  3  per-approach vehicle presence, level
- ped_req  in  2  crossing push-buttons (bit0 main road, bit1 side road), pulse or level
- emg_req  in  3  per-approach emergency request, level
- lights  out  9  approach a lamps at [3a+2:3a] = {red,yellow,green}, one-hot
- walk  out  2  walk lamp per crossing
- buzzer  out  1  emergency warning
- emg_active  out  1  high in the EMG state
- phase  out  2  approach currently owning the junction (0..2)

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `reset`. All state and outputs are registered.
- Reset values:
  - state = ALLRED; phase = 2, so the first green goes to approach 0.
  - Tick counter cnt = 0; ped_pending = 0.
  - lights = 9'b100100100; walk = 0; buzzer = 0; emg_active = 0.
  - Reset asserted mid-operation overrides everything on the next edge.
- Counter:
  - 8-bit cnt increments only on tick. It clears on every state change.
  - A timed state exits on the tick where cnt == T-1, so it lasts exactly T ticks. Outputs change the cycle after that tick edge.
- Pedestrian latch: ped_pending |= ped_req every cycle. Pending bits are cleared on entry to WALK.
- GREEN(phase):
  - Lamp output: phase approach green, others red.
  - Other demand = veh_req on a different approach, or any ped_pending.
  - Exit to YELLOW when cnt >= GREEN_MIN-1 on a tick, other demand exists, and either veh_req[phase] == 0 or cnt >= GREEN_MAX-1.
  - With no other demand, green rests indefinitely; cnt saturates at 255.
- YELLOW: phase approach yellow, others red. Lasts YELLOW_T, then goes to ALLRED.
- ALLRED:
  - All red. Lasts ALLRED_T. Next state is chosen in priority order:
  - If an emergency is pending, go to EMG.
  - Else if ped_pending != 0, go to WALK.
  - Else go to GREEN. The next phase is the first approach with veh_req in the order phase+1, phase+2, phase (mod 3). With no requests, next phase = phase+1 mod 3.
- WALK:
  - All vehicle lamps red. walk = the pending bits latched at entry.
  - Lasts WALK_T, then GREEN with the next-phase selection above.
  - Button presses during WALK are latched for the next walk.
- EMG arbitration:
  - Fixed priority, lowest index wins. The grant is latched on entry and held until exit.
  - From GREEN: if phase equals the winner, go directly to EMG with no yellow. Otherwise go to YELLOW, then ALLRED, then EMG. Timers are not shortened.
  - From WALK: walk ends immediately into ALLRED. ped_pending is not re-latched; served bits are lost.
  - From YELLOW or ALLRED: continue the normal sequence to ALLRED exit.
- EMG:
  - Granted approach green, others red. buzzer = 1, emg_active = 1, walk = 0, phase = grant.
  - Exits to YELLOW(grant) once emg_req[grant] == 0 and cnt >= EMG_HOLD-1 on a tick.
  - Requests from other approaches during EMG are ignored until the next ALLRED exit. Then they win again if still high.
- Invariants:
  - At most one approach is non-red at any time.
  - walk is nonzero only in WALK.
  - Every lights field is one-hot.

Test Plan:
- Reset, then veh_req=3'b011 steady → A0 green for exactly GREEN_MAX ticks (30), then 3 yellow, 2 all-red, then A1 green; A2 is never served.
- A0 green with veh_req=0, ped_req[1] pulse at tick 4 → yellow at tick 10, all-red for 2, walk=2'b10 for 8 ticks, then A1 green.
- A1 green, emg_req=3'b100 held for 5 ticks → yellow, all-red, EMG on A2 with buzzer=1 for 20 ticks, then A2 yellow, all-red, and normal A0 selection.
- emg_req=3'b110 while A0 green → grant A1, not A2. Release A1 after hold → A2 wins at the next ALLRED exit.
- During WALK, emg_req[0]=1 → walk drops next cycle, 2-tick all-red, then EMG on A0.
- Assert reset during EMG → next cycle all lamps red, buzzer 0, phase 2, state ALLRED.
